// File: rtl/picorv32_pcpi_issue_if.sv
// Request, PCPI and response signal bundle for the PCPI issue unit.
// The master view belongs to the issue unit. The slave view is the
// surrounding core plus the attached coprocessor.
interface picorv32_pcpi_issue_if;
   // request port from the core
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_insn;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;

   // PCPI bus towards the coprocessor
   logic        pcpi_valid;
   logic [31:0] pcpi_insn;
   logic [31:0] pcpi_rs1;
   logic [31:0] pcpi_rs2;
   logic        pcpi_wr;
   logic [31:0] pcpi_rd;
   logic        pcpi_wait;
   logic        pcpi_ready;

   // response port back to the core
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_wr;
   logic [31:0] rsp_rd;
   logic        rsp_trap;

   modport master (
      input  req_valid, req_insn, req_rs1, req_rs2,
      output req_ready,
      output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
      output rsp_valid, rsp_wr, rsp_rd, rsp_trap,
      input  rsp_ready
   );

   modport slave (
      output req_valid, req_insn, req_rs1, req_rs2,
      input  req_ready,
      input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
      input  rsp_valid, rsp_wr, rsp_rd, rsp_trap,
      output rsp_ready
   );
endinterface

// File: rtl/picorv32_pcpi_issue.sv
// Core-side initiator of the PCPI coprocessor interface.
// The unit issues one instruction at a time and returns either the
// coprocessor result or a trap when no coprocessor claims the
// instruction before the timeout window expires.
module picorv32_pcpi_issue #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      resetn,
   picorv32_pcpi_issue_if.master     bus,
   output logic                      busy
);

   localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt, cnt_nxt, cnt_dec;

   logic        pcpi_valid_q;
   logic [31:0] pcpi_insn_q, pcpi_insn_nxt;
   logic [31:0] pcpi_rs1_q, pcpi_rs1_nxt;
   logic [31:0] pcpi_rs2_q, pcpi_rs2_nxt;
   logic        rsp_valid_q;
   logic        rsp_wr_q, rsp_wr_nxt;
   logic [31:0] rsp_rd_q, rsp_rd_nxt;
   logic        rsp_trap_q, rsp_trap_nxt;

   // saturating decrement: the counter never wraps below zero
   assign cnt_dec = (cnt == '0) ? '0 : cnt - 8'd1;

   // state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // next-state, timeout counter and captured-field decode
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      pcpi_insn_nxt = pcpi_insn_q;
      pcpi_rs1_nxt  = pcpi_rs1_q;
      pcpi_rs2_nxt  = pcpi_rs2_q;
      rsp_wr_nxt    = rsp_wr_q;
      rsp_rd_nxt    = rsp_rd_q;
      rsp_trap_nxt  = rsp_trap_q;
      unique case (state)
         S_IDLE: begin
            if (bus.req_valid) begin
               pcpi_insn_nxt = bus.req_insn;
               pcpi_rs1_nxt  = bus.req_rs1;
               pcpi_rs2_nxt  = bus.req_rs2;
               cnt_nxt       = TIMEOUT_LOAD;
               state_nxt     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // a ready pulse beats a simultaneous expiry
            if (bus.pcpi_ready) begin
               rsp_wr_nxt   = bus.pcpi_wr;
               rsp_rd_nxt   = bus.pcpi_wr ? bus.pcpi_rd : '0;
               rsp_trap_nxt = 1'b0;
               state_nxt    = S_RESP;
            end else if (bus.pcpi_wait) begin
               cnt_nxt = TIMEOUT_LOAD;
            end else begin
               cnt_nxt = cnt_dec;
               if (cnt_dec == '0) begin
                  rsp_wr_nxt   = 1'b0;
                  rsp_rd_nxt   = '0;
                  rsp_trap_nxt = 1'b1;
                  state_nxt    = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // registered outputs; valids are decoded from the next state so they
   // change on the same edge as the state itself
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt          <= '0;
         pcpi_valid_q <= 1'b0;
         pcpi_insn_q  <= '0;
         pcpi_rs1_q   <= '0;
         pcpi_rs2_q   <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_wr_q     <= 1'b0;
         rsp_rd_q     <= '0;
         rsp_trap_q   <= 1'b0;
      end else begin
         cnt          <= cnt_nxt;
         pcpi_valid_q <= (state_nxt == S_ISSUE);
         pcpi_insn_q  <= pcpi_insn_nxt;
         pcpi_rs1_q   <= pcpi_rs1_nxt;
         pcpi_rs2_q   <= pcpi_rs2_nxt;
         rsp_valid_q  <= (state_nxt == S_RESP);
         rsp_wr_q     <= rsp_wr_nxt;
         rsp_rd_q     <= rsp_rd_nxt;
         rsp_trap_q   <= rsp_trap_nxt;
      end
   end

   assign bus.req_ready  = (state == S_IDLE);
   assign busy           = (state != S_IDLE);
   assign bus.pcpi_valid = pcpi_valid_q;
   assign bus.pcpi_insn  = pcpi_insn_q;
   assign bus.pcpi_rs1   = pcpi_rs1_q;
   assign bus.pcpi_rs2   = pcpi_rs2_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_wr     = rsp_wr_q;
   assign bus.rsp_rd     = rsp_rd_q;
   assign bus.rsp_trap   = rsp_trap_q;

endmodule

// File: tb/tb_picorv32_pcpi_issue.sv
// Self-checking bench for picorv32_pcpi_issue. A cycle-driven coprocessor
// model (M-extension divide unit or scripted stub) answers the PCPI bus and
// a run-length timeout model predicts when and how each response appears.
module tb_picorv32_pcpi_issue;

   localparam int unsigned TO   = 16;
   localparam int unsigned SMAX = 600;

   logic clk = 1'b0;
   logic resetn;
   logic busy;

   picorv32_pcpi_issue_if pif ();

   picorv32_pcpi_issue #(.TIMEOUT_CYCLES(TO)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (pif),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   int unsigned n_chk = 0;
   int unsigned n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h want %08h", tag, got, exp);
      end
   endtask

   // coprocessor schedule for one transaction, indexed by ISSUE cycle (1-based)
   bit          sched_wait [0:SMAX-1];
   int unsigned ready_at;      // 0: coprocessor never signals ready
   bit          ready_wr;
   logic [31:0] ready_rd;

   task automatic clear_sched();
      for (int unsigned k = 0; k < SMAX; k++) sched_wait[k] = 1'b0;
      ready_at = 0;
      ready_wr = 1'b0;
      ready_rd = '0;
   endtask

   // RISC-V M-extension divide/remainder semantics
   function automatic void m_model(input logic [31:0] insn, input logic [31:0] a,
                                   input logic [31:0] b, output bit claimed,
                                   output logic [31:0] r);
      bit ovf;
      claimed = (insn[6:0] == 7'h33) && (insn[31:25] == 7'h01) && insn[14];
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      r = '0;
      case (insn[13:12])
         2'd0: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
         2'd1: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         2'd2: r = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         default: r = (b == 0) ? a : a % b;
      endcase
   endfunction

   // divider-style responder: busy (optionally with wait) until lat, then ready
   task automatic set_coproc(input logic [31:0] insn, input logic [31:0] a,
                             input logic [31:0] b, input int unsigned lat, input bit wflag);
      bit claimed;
      logic [31:0] r;
      clear_sched();
      m_model(insn, a, b, claimed, r);
      if (claimed) begin
         ready_at = lat;
         ready_wr = 1'b1;
         ready_rd = r;
         for (int unsigned k = 1; k < lat; k++) sched_wait[k] = wflag;
      end
   endtask

   // response arrives at the first ready cycle, or when TO consecutive
   // cycles have passed without wait or ready
   function automatic void predict(output int unsigned kend, output bit trap);
      int unsigned run;
      run  = 0;
      kend = SMAX - 1;
      trap = 1'b1;
      for (int unsigned k = 1; k < SMAX; k++) begin
         if (k == ready_at) begin
            kend = k;
            trap = 1'b0;
            return;
         end
         if (sched_wait[k]) run = 0;
         else               run++;
         if (run == TO) begin
            kend = k;
            return;
         end
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input string nm, input logic [31:0] insn, input logic [31:0] a,
                          input logic [31:0] b, input int unsigned bp);
      int unsigned kend;
      bit          trap;
      bit          e_wr;
      logic [31:0] e_rd;
      predict(kend, trap);
      e_wr = trap ? 1'b0 : ready_wr;
      e_rd = (trap || !ready_wr) ? 32'd0 : ready_rd;

      check({nm, ".req_ready_idle"}, 32'(pif.req_ready), 32'd1);
      pif.req_valid = 1'b1;
      pif.req_insn  = insn;
      pif.req_rs1   = a;
      pif.req_rs2   = b;
      pif.rsp_ready = 1'b0;
      step();
      pif.req_valid = 1'b0;
      check({nm, ".pcpi_valid_acc"}, 32'(pif.pcpi_valid), 32'd1);
      check({nm, ".pcpi_rs1"}, pif.pcpi_rs1, a);
      check({nm, ".pcpi_rs2"}, pif.pcpi_rs2, b);
      check({nm, ".busy_acc"}, 32'(busy), 32'd1);
      check({nm, ".req_ready_acc"}, 32'(pif.req_ready), 32'd0);

      for (int unsigned k = 1; k <= kend; k++) begin
         // spurious requests during ISSUE must not disturb the held fields
         pif.req_valid  = 1'($urandom_range(0, 1));
         pif.req_insn   = $urandom;
         pif.req_rs1    = $urandom;
         pif.req_rs2    = $urandom;
         pif.pcpi_wait  = sched_wait[k];
         pif.pcpi_ready = (k == ready_at);
         pif.pcpi_wr    = (k == ready_at) ? ready_wr : 1'($urandom_range(0, 1));
         pif.pcpi_rd    = (k == ready_at) ? ready_rd : $urandom;
         step();
         if (k < kend) begin
            check({nm, ".pcpi_valid_issue"}, 32'(pif.pcpi_valid), 32'd1);
            check({nm, ".rsp_valid_issue"}, 32'(pif.rsp_valid), 32'd0);
            check({nm, ".pcpi_insn_hold"}, pif.pcpi_insn, insn);
         end
      end
      pif.req_valid  = 1'b0;
      pif.pcpi_wait  = 1'b0;
      pif.pcpi_ready = 1'b0;

      check({nm, ".rsp_valid"}, 32'(pif.rsp_valid), 32'd1);
      check({nm, ".pcpi_valid_drop"}, 32'(pif.pcpi_valid), 32'd0);
      check({nm, ".rsp_trap"}, 32'(pif.rsp_trap), 32'(trap));
      check({nm, ".rsp_wr"}, 32'(pif.rsp_wr), 32'(e_wr));
      check({nm, ".rsp_rd"}, pif.rsp_rd, e_rd);

      // back-pressure; stray ready pulses here must be ignored
      for (int unsigned c = 0; c < bp; c++) begin
         pif.pcpi_ready = 1'($urandom_range(0, 1));
         pif.pcpi_wr    = 1'($urandom_range(0, 1));
         pif.pcpi_rd    = $urandom;
         step();
         check({nm, ".bp_valid"}, 32'(pif.rsp_valid), 32'd1);
         check({nm, ".bp_rd"}, pif.rsp_rd, e_rd);
         check({nm, ".bp_flags"}, {30'd0, pif.rsp_wr, pif.rsp_trap}, {30'd0, e_wr, trap});
         check({nm, ".bp_req_ready"}, 32'(pif.req_ready), 32'd0);
         check({nm, ".bp_pcpi_valid"}, 32'(pif.pcpi_valid), 32'd0);
      end
      pif.pcpi_ready = 1'b0;
      pif.rsp_ready  = 1'b1;
      step();
      pif.rsp_ready = 1'b0;
      check({nm, ".rsp_done"}, 32'(pif.rsp_valid), 32'd0);
      check({nm, ".idle_busy"}, 32'(busy), 32'd0);
      check({nm, ".idle_req_ready"}, 32'(pif.req_ready), 32'd1);
      check({nm, ".idle_pcpi_valid"}, 32'(pif.pcpi_valid), 32'd0);
   endtask

   task automatic check_reset_state(input string nm);
      check({nm, ".pcpi_valid"}, 32'(pif.pcpi_valid), 32'd0);
      check({nm, ".pcpi_fields"}, pif.pcpi_insn | pif.pcpi_rs1 | pif.pcpi_rs2, 32'd0);
      check({nm, ".rsp_flags"}, {29'd0, pif.rsp_valid, pif.rsp_wr, pif.rsp_trap}, 32'd0);
      check({nm, ".rsp_rd"}, pif.rsp_rd, 32'd0);
      check({nm, ".req_ready"}, 32'(pif.req_ready), 32'd1);
      check({nm, ".busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] insn, a, b;
      int unsigned mode, lat;

      resetn         = 1'b0;
      pif.req_valid  = 1'b0;
      pif.req_insn   = '0;
      pif.req_rs1    = '0;
      pif.req_rs2    = '0;
      pif.pcpi_wr    = 1'b0;
      pif.pcpi_rd    = '0;
      pif.pcpi_wait  = 1'b0;
      pif.pcpi_ready = 1'b0;
      pif.rsp_ready  = 1'b0;
      clear_sched();
      #1;
      check_reset_state("por");
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      step();

      // DIVU 100/7
      set_coproc(32'h0200_5033, 32'd100, 32'd7, 34, 1'b1);
      run_txn("divu", 32'h0200_5033, 32'd100, 32'd7, 0);
      // DIV signed, then back-to-back REMU
      set_coproc(32'h0200_4033, 32'hFFFF_FFF9, 32'd2, 34, 1'b1);
      run_txn("div", 32'h0200_4033, 32'hFFFF_FFF9, 32'd2, 0);
      set_coproc(32'h0200_7033, 32'd100, 32'd7, 34, 1'b1);
      run_txn("remu", 32'h0200_7033, 32'd100, 32'd7, 0);
      // unclaimed instruction: trap after exactly TO cycles
      set_coproc(32'h0000_0033, 32'd5, 32'd6, 1, 1'b1);
      run_txn("timeout", 32'h0000_0033, 32'd5, 32'd6, 0);
      // wait raised at cycle 15 for 40 cycles, then ready with data
      clear_sched();
      for (int unsigned k = 15; k < 55; k++) sched_wait[k] = 1'b1;
      ready_at = 55;
      ready_wr = 1'b1;
      ready_rd = 32'hCAFE_BABE;
      run_txn("wait_refresh", 32'h1234_5677, 32'd1, 32'd2, 0);
      // ready without writeback in the cycle the counter would expire
      clear_sched();
      ready_at = TO;
      ready_wr = 1'b0;
      run_txn("ready_vs_expiry", 32'h0000_000B, 32'd3, 32'd4, 0);
      // long back-pressure
      set_coproc(32'h0200_5033, 32'd1000, 32'd33, 5, 1'b0);
      run_txn("backpressure", 32'h0200_5033, 32'd1000, 32'd33, 10);

      // asynchronous reset while an instruction is in ISSUE
      pif.req_valid = 1'b1;
      pif.req_insn  = 32'h0200_5033;
      pif.req_rs1   = 32'd77;
      pif.req_rs2   = 32'd5;
      step();
      pif.req_valid = 1'b0;
      pif.pcpi_wait = 1'b1;
      repeat (3) step();
      check("pre_reset.pcpi_valid", 32'(pif.pcpi_valid), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      check_reset_state("mid_issue_reset");
      pif.pcpi_wait = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      step();
      check_reset_state("post_reset");
      set_coproc(32'h0200_5033, 32'd100, 32'd7, 34, 1'b1);
      run_txn("divu_after_reset", 32'h0200_5033, 32'd100, 32'd7, 0);

      // randomized traffic
      for (int unsigned t = 0; t < 40; t++) begin
         mode = $urandom_range(0, 3);
         a    = $urandom;
         b    = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         insn = $urandom;
         case (mode)
            0: begin
               insn[31:25] = 7'h01;
               insn[14]    = 1'b1;
               insn[6:0]   = 7'h33;
               lat = $urandom_range(1, 40);
               set_coproc(insn, a, b, lat, ($urandom_range(0, 3) != 0));
            end
            1: begin
               insn[6:0] = 7'h13;
               set_coproc(insn, a, b, 1, 1'b1);
            end
            2: begin
               clear_sched();
               for (int unsigned k = 1; k <= 60; k++)
                  sched_wait[k] = ($urandom_range(0, 2) == 0);
               ready_at = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 80);
               ready_wr = 1'($urandom_range(0, 1));
               ready_rd = $urandom;
            end
            default: begin
               clear_sched();
               ready_at = $urandom_range(TO - 1, TO + 1);
               ready_wr = 1'($urandom_range(0, 1));
               ready_rd = $urandom;
            end
         endcase
         run_txn($sformatf("rnd%0d", t), insn, a, b, $urandom_range(0, 4));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
